tiny_dnn_ex_seq: RTL and testbench

//  Sample-level sequencer in front of the conv execution controller. Accepts one host command
//  (N samples, fwd/backprop), issues one s_init pulse per sample, waits for s_fin, advances the

---
 rtl/tiny_dnn_ex_seq.sv | 187 ++++++++++++++++++
 tb/tb_tiny_dnn_ex_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_dnn_ex_seq.sv
// Sample-level sequencer for the conv execution controller: one s_init per sample, host write arbitration.
// Optional watchdog enabled by defining TINY_DNN_SEQ_WDT_EN.
module tiny_dnn_ex_seq #(
  parameter int unsigned SW    = 10,
  parameter int unsigned WDT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_bp,
  input  logic [SW-1:0]    cmd_cnt,
  input  logic             abort,
  input  logic             wr_req,
  output logic             wr_gnt,
  output logic             s_init,
  input  logic             s_fin,
  output logic             backprop,
  output logic [SW-1:0]    smp,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  input  logic [WDT_W-1:0] wdt_max,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_s_init;
  logic          r_busy;
  logic          r_done;
  logic          r_backprop;
  logic          r_aborted;
  logic          r_abort_pend;
  logic [SW-1:0] r_smp;
  logic [SW-1:0] r_cnt;
  logic          w_idle_free;
  logic          w_accept;
  logic          w_set_aborted;
  logic          w_smp_inc;
  logic          w_abort_req;
  logic          w_timeout;
  logic          w_in_wait;

  // busy stays high through the done pulse, so host access opens only once both have dropped
  assign w_idle_free = (r_state == S_IDLE) && !r_busy;
  assign cmd_ready   = w_idle_free && !wr_req;
  assign wr_gnt      = w_idle_free && wr_req;
  assign w_in_wait   = (r_state == S_WAIT) || (r_state == S_DRAIN);
  assign w_abort_req = abort || r_abort_pend;

`ifdef TINY_DNN_SEQ_WDT_EN
  logic [WDT_W-1:0] r_wdt;
  logic             r_err;
  logic             w_wdt_clr;

  assign w_timeout = w_in_wait && !s_fin && (wdt_max != '0) && (r_wdt == wdt_max - 1'b1);
  assign w_wdt_clr = ((w_next == S_WAIT) && (r_state != S_WAIT)) ||
                     ((w_next == S_DRAIN) && (r_state != S_DRAIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_wdt_clr) begin
        r_wdt <= '0;
      end else if (w_in_wait && (r_wdt != '1)) begin
        r_wdt <= r_wdt + 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  logic w_unused_wdt;

  assign w_unused_wdt = ^{wdt_max, w_in_wait};
  assign w_timeout    = 1'b0;
  assign err          = 1'b0;
`endif

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_set_aborted = 1'b0;
    w_smp_inc     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          w_accept = 1'b1;
          w_next   = S_INIT;
        end
      end
      S_INIT: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (s_fin) begin
          if (w_abort_req) begin
            w_next        = S_DONE;
            w_set_aborted = 1'b1;
          end else if (r_smp == r_cnt) begin
            w_next = S_DONE;
          end else begin
            w_smp_inc = 1'b1;
            w_next    = S_INIT;
          end
        end else if (w_timeout) begin
          w_next        = S_DONE;
          w_set_aborted = 1'b1;
        end else if (w_abort_req) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (s_fin || w_timeout) begin
          w_next        = S_DONE;
          w_set_aborted = 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_s_init     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_backprop   <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
      r_smp        <= '0;
      r_cnt        <= '0;
    end else begin
      r_state  <= w_next;
      r_s_init <= (w_next == S_INIT);
      r_done   <= (r_state == S_DONE);
      r_busy   <= (w_next != S_IDLE) || (r_state == S_DONE);
      if (w_accept) begin
        r_backprop <= cmd_bp;
        r_cnt      <= cmd_cnt;
        r_smp      <= '0;
        r_aborted  <= 1'b0;
      end else begin
        if (w_smp_inc) begin
          r_smp <= r_smp + 1'b1;
        end
        if (w_set_aborted) begin
          r_aborted <= 1'b1;
        end
      end
      // an abort seen during INIT is held so WAIT can act on it
      case (r_state)
        S_INIT:  r_abort_pend <= r_abort_pend || abort;
        S_WAIT:  r_abort_pend <= r_abort_pend;
        default: r_abort_pend <= 1'b0;
      endcase
    end
  end

  assign s_init   = r_s_init;
  assign busy     = r_busy;
  assign done     = r_done;
  assign backprop = r_backprop;
  assign aborted  = r_aborted;
  assign smp      = r_smp;

endmodule

// File: tb/tb_tiny_dnn_ex_seq.sv
// Directed self-checking bench for tiny_dnn_ex_seq; watchdog steps run when TINY_DNN_SEQ_WDT_EN is defined.
module tb_tiny_dnn_ex_seq;
  localparam int unsigned SW    = 10;
  localparam int unsigned WDT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_bp = 1'b0;
  logic [SW-1:0]    cmd_cnt = '0;
  logic             abort = 1'b0;
  logic             wr_req = 1'b0;
  logic             wr_gnt;
  logic             s_init;
  logic             s_fin = 1'b0;
  logic             backprop;
  logic [SW-1:0]    smp;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [WDT_W-1:0] wdt_max = '0;
  logic             err;

  int total = 0;
  int bad   = 0;
  int n_init = 0;
  int n_done = 0;
  int base_init;
  int base_done;

  tiny_dnn_ex_seq #(.SW(SW), .WDT_W(WDT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_bp(cmd_bp),
    .cmd_cnt(cmd_cnt), .abort(abort), .wr_req(wr_req), .wr_gnt(wr_gnt), .s_init(s_init),
    .s_fin(s_fin), .backprop(backprop), .smp(smp), .busy(busy), .done(done),
    .aborted(aborted), .wdt_max(wdt_max), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (s_init === 1'b1) n_init++;
    if (done === 1'b1) n_done++;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic bp, input logic [SW-1:0] cnt);
    cmd_bp    = bp;
    cmd_cnt   = cnt;
    cmd_valid = 1'b1;
    #1;
    chk("accept_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic fin();
    s_fin = 1'b1;
    step();
    s_fin = 1'b0;
  endtask

  initial begin
    // reset values
    step(2);
    rst = 1'b0;
    #1;
    chk("rst_s_init", s_init, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_backprop", backprop, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_smp", smp, 0);
    chk("rst_err", err, 0);

    // three forward samples, s_fin 20 cycles after each s_init
    base_init = n_init; base_done = n_done;
    accept(1'b0, 10'd2);
    for (int i = 0; i < 3; i++) begin
      chk("t1_s_init", s_init, 1);
      chk("t1_smp", smp, i);
      chk("t1_bp", backprop, 0);
      step(20);
      fin();
    end
    chk("t1_done_early", done, 0);
    chk("t1_smp_last", smp, 2);
    step();
    chk("t1_done", done, 1);
    chk("t1_busy_in_done", busy, 1);
    step();
    chk("t1_done_low", done, 0);
    chk("t1_busy_low", busy, 0);
    chk("t1_aborted", aborted, 0);
    chk("t1_n_init", n_init - base_init, 3);
    chk("t1_n_done", n_done - base_done, 1);

    // single backprop sample
    base_init = n_init;
    accept(1'b1, 10'd0);
    chk("t2_s_init", s_init, 1);
    chk("t2_bp", backprop, 1);
    step(3);
    fin();
    chk("t2_done_f1", done, 0);
    chk("t2_bp_hold", backprop, 1);
    step();
    chk("t2_done_f2", done, 1);
    step();
    chk("t2_busy_after", busy, 0);
    chk("t2_n_init", n_init - base_init, 1);

    // write arbitration
    wr_req = 1'b1; cmd_valid = 1'b1; cmd_bp = 1'b0; cmd_cnt = 10'd1;
    #1;
    chk("t3_gnt", wr_gnt, 1);
    chk("t3_ready_held", cmd_ready, 0);
    step(2);
    chk("t3_not_accepted", busy, 0);
    wr_req = 1'b0;
    #1;
    chk("t3_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("t3_s_init", s_init, 1);
    wr_req = 1'b1;
    #1;
    chk("t3_gnt_busy", wr_gnt, 0);
    step(2);
    fin();
    chk("t3_s_init2", s_init, 1);
    step(2);
    fin();
    chk("t3_gnt_donestate", wr_gnt, 0);
    step();
    chk("t3_done", done, 1);
    chk("t3_gnt_done", wr_gnt, 0);
    step();
    chk("t3_gnt_after", wr_gnt, 1);
    wr_req = 1'b0;
    step();

    // abort during sample 2, then abort coincident with s_fin
    base_init = n_init;
    accept(1'b0, 10'd5);
    step(2);
    fin();
    step(2);
    fin();
    chk("t4_smp2", smp, 2);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step(3);
    chk("t4_no_more_init", n_init - base_init, 3);
    chk("t4_busy_drain", busy, 1);
    fin();
    chk("t4_aborted", aborted, 1);
    chk("t4_smp_hold", smp, 2);
    step();
    chk("t4_done", done, 1);
    step();
    chk("t4_busy_low", busy, 0);
    base_init = n_init;
    accept(1'b0, 10'd5);
    chk("t4_aborted_clr", aborted, 0);
    step();
    abort = 1'b1; s_fin = 1'b1;
    step();
    abort = 1'b0; s_fin = 1'b0;
    chk("t4b_aborted", aborted, 1);
    chk("t4b_smp", smp, 0);
    step();
    chk("t4b_done", done, 1);
    step();
    chk("t4b_busy_low", busy, 0);
    chk("t4b_n_init", n_init - base_init, 1);

    // reset mid-command
    accept(1'b1, 10'd3);
    step();
    fin();
    step();
    chk("t5_smp1", smp, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    base_init = n_init; base_done = n_done;
    chk("t5_smp", smp, 0);
    chk("t5_busy", busy, 0);
    chk("t5_bp", backprop, 0);
    chk("t5_s_init", s_init, 0);
    chk("t5_done", done, 0);
    fin();
    step(3);
    chk("t5_late_fin_busy", busy, 0);
    chk("t5_no_done", n_done - base_done, 0);
    chk("t5_no_init", n_init - base_init, 0);

`ifdef TINY_DNN_SEQ_WDT_EN
    // watchdog fires 8 cycles after WAIT entry
    wdt_max = 16'd8;
    accept(1'b0, 10'd0);
    step();
    step(7);
    chk("t6_err_pre", err, 0);
    step();
    chk("t6_err", err, 1);
    chk("t6_aborted", aborted, 1);
    step();
    chk("t6_done", done, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wdt_max = '0;
    base_done = n_done;
    accept(1'b0, 10'd0);
    step(40);
    chk("t6_hang_busy", busy, 1);
    chk("t6_hang_err", err, 0);
    chk("t6_hang_nodone", n_done - base_done, 0);
    fin();
    step(3);
    chk("t6_recover", busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
